// File: rtl/mci_sec_state_filter.sv
// Fault-hardening filter between the LCC state translator and its consumers:
// locking changes pass in one cycle, unlocking changes must be held stable first.
module mci_sec_state_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CHG_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 otp_data_valid_i,
    input  logic [2:0]           security_state_i,
    input  logic                 dft_en_i,
    input  logic                 hw_debug_en_i,
    output logic [2:0]           security_state_o,
    output logic                 soc_dft_en_o,
    output logic                 soc_hw_debug_en_o,
    output logic                 state_error_o,
    output logic                 state_chg_pulse_o,
    output logic [CHG_CNT_W-1:0] chg_cnt_o
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [1:0]  LC_PROD = 2'b11;
    localparam logic [1:0]  LC_RSVD = 2'b10;
    // Field vector layout: {lifecycle[1:0], debug_locked, dft_en, hw_debug_en}
    localparam logic [4:0]  SAFE    = 5'b11100;
    localparam logic [CHG_CNT_W-1:0] CNT_MAX = {CHG_CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, ERROR} state_t;

    state_t               state_q, state_d;
    logic [4:0]           cand_q, cand_d;
    logic [4:0]           comm_q, comm_d;
    logic [4:0]           out_q, out_d;
    logic [STAB_W-1:0]    stab_q, stab_d;
    logic                 err_q, err_d;
    logic                 pulse_q, pulse_d;
    logic [CHG_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           first_lc_q, first_lc_d;
    logic                 first_vld_q, first_vld_d;

    logic [4:0]        in_v;
    logic [4:0]        merged;
    logic              unlock, lc_ok, err_hit, reached;
    logic              commit, drop, fault;
    logic [STAB_W-1:0] stab_inc;

    assign in_v     = {security_state_i, dft_en_i, hw_debug_en_i};
    assign unlock   = (comm_q[2] & ~in_v[2]) | (~comm_q[1] & in_v[1]) | (~comm_q[0] & in_v[0]);
    assign lc_ok    = (in_v[4:3] == comm_q[4:3]) || (in_v[4:3] == LC_PROD);
    assign err_hit  = (in_v[4:3] == LC_RSVD) ||
                      (first_vld_q && (in_v[4:3] != first_lc_q) && (in_v[4:3] != LC_PROD));
    // While settling each field shows the more-locked of committed and live input
    assign merged   = {comm_q[4:3], comm_q[2] | in_v[2], comm_q[1] & in_v[1], comm_q[0] & in_v[0]};
    assign stab_inc = stab_q + STAB_W'(1);
    assign reached  = (stab_inc == STAB_W'(STABLE_CYCLES));

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        comm_d      = comm_q;
        out_d       = out_q;
        stab_d      = stab_q;
        err_d       = err_q;
        first_lc_d  = first_lc_q;
        first_vld_d = first_vld_q;
        commit      = 1'b0;
        drop        = 1'b0;
        fault       = 1'b0;

        case (state_q)
            IDLE: begin
                out_d = SAFE;
                if (otp_data_valid_i) begin
                    if (STABLE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        cand_d  = in_v;
                        stab_d  = STAB_W'(1);
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!otp_data_valid_i) begin
                    drop = 1'b1;
                end else if (err_hit) begin
                    fault = 1'b1;
                end else if (in_v == cand_q) begin
                    if (reached) begin
                        commit = 1'b1;
                    end else begin
                        stab_d = stab_inc;
                        out_d  = merged;
                    end
                end else begin
                    cand_d = in_v;
                    stab_d = STAB_W'(1);
                    out_d  = merged;
                end
            end
            ACTIVE: begin
                if (!otp_data_valid_i) begin
                    drop = 1'b1;
                end else if (err_hit) begin
                    fault = 1'b1;
                end else if (in_v == comm_q) begin
                    out_d = comm_q;
                end else if ((!unlock && lc_ok) || (STABLE_CYCLES == 1)) begin
                    commit = 1'b1;
                end else begin
                    cand_d  = in_v;
                    stab_d  = STAB_W'(1);
                    out_d   = comm_q;
                    state_d = SETTLE;
                end
            end
            default: begin
                out_d = SAFE;
            end
        endcase

        if (commit) begin
            comm_d  = in_v;
            out_d   = in_v;
            stab_d  = '0;
            state_d = ACTIVE;
            if (!first_vld_q) begin
                first_vld_d = 1'b1;
                first_lc_d  = in_v[4:3];
            end
        end
        if (drop) begin
            comm_d      = SAFE;
            out_d       = SAFE;
            stab_d      = '0;
            first_vld_d = 1'b0;
            state_d     = IDLE;
        end
        if (fault) begin
            err_d   = 1'b1;
            out_d   = SAFE;
            stab_d  = '0;
            state_d = ERROR;
        end

        pulse_d = (out_d != out_q);
        cnt_d   = (pulse_d && (cnt_q != CNT_MAX)) ? cnt_q + CHG_CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= SAFE;
            comm_q      <= SAFE;
            out_q       <= SAFE;
            stab_q      <= '0;
            err_q       <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
            first_lc_q  <= 2'b00;
            first_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            comm_q      <= comm_d;
            out_q       <= out_d;
            stab_q      <= stab_d;
            err_q       <= err_d;
            pulse_q     <= pulse_d;
            cnt_q       <= cnt_d;
            first_lc_q  <= first_lc_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign security_state_o  = out_q[4:2];
    assign soc_dft_en_o      = out_q[1];
    assign soc_hw_debug_en_o = out_q[0];
    assign state_error_o     = err_q;
    assign state_chg_pulse_o = pulse_q;
    assign chg_cnt_o         = cnt_q;

endmodule

// File: tb/tb_mci_sec_state_filter.sv
// Directed self-checking bench for mci_sec_state_filter (STABLE_CYCLES=4, CHG_CNT_W=8).
module tb_mci_sec_state_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [2:0] sec_in;
    logic       dft_in, hw_in;
    logic [2:0] sec_out;
    logic       dft_out, hw_out, err, pulse;
    logic [7:0] cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Output vector expectations: {lifecycle, debug_locked, dft, hw}
    localparam logic [7:0] SAFE_V = 8'h1C;

    mci_sec_state_filter #(.STABLE_CYCLES(4), .CHG_CNT_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .otp_data_valid_i  (valid),
        .security_state_i  (sec_in),
        .dft_en_i          (dft_in),
        .hw_debug_en_i     (hw_in),
        .security_state_o  (sec_out),
        .soc_dft_en_o      (dft_out),
        .soc_hw_debug_en_o (hw_out),
        .state_error_o     (err),
        .state_chg_pulse_o (pulse),
        .chg_cnt_o         (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] out_v();
        return {3'b000, sec_out, dft_out, hw_out};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic d, input logic h);
        valid  = v;
        sec_in = s;
        dft_in = d;
        hw_in  = h;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_out", out_v(), SAFE_V);
        chk("rst_err", 8'(err), 8'h00);
        chk("rst_pulse", 8'(pulse), 8'h00);
        chk("rst_cnt", cnt, 8'h00);

        // First commit: {MANUF,1},0,0 visible on the 4th edge
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        tick(); chk("t1_e1_out", out_v(), SAFE_V);
        tick(); chk("t1_e2_out", out_v(), SAFE_V);
        tick(); chk("t1_e3_out", out_v(), SAFE_V);
        chk("t1_e3_pulse", 8'(pulse), 8'h00);
        tick(); chk("t1_e4_out", out_v(), 8'h0C);
        chk("t1_e4_pulse", 8'(pulse), 8'h01);
        chk("t1_e4_cnt", cnt, 8'h01);
        tick(); chk("t1_e5_pulse", 8'(pulse), 8'h00);
        chk("t1_e5_cnt", cnt, 8'h01);

        // Lock-direction change passes in one edge
        do_reset();
        drive(1'b1, 3'b000, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("t2_e3_out", out_v(), SAFE_V);
        tick(); chk("t2_e4_out", out_v(), 8'h02);
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        tick(); chk("t2_lock_out", out_v(), SAFE_V);
        chk("t2_lock_pulse", 8'(pulse), 8'h01);
        chk("t2_lock_err", 8'(err), 8'h00);
        chk("t2_lock_cnt", cnt, 8'h02);
        // Valid drop clears the first-lifecycle record, so MANUF is legal afterwards
        drive(1'b0, 3'b111, 1'b0, 1'b0);
        tick(); chk("t2_drop_out", out_v(), SAFE_V);
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t2_reentry_out", out_v(), 8'h0C);
        chk("t2_reentry_err", 8'(err), 8'h00);

        // Toggling unlock request never reaches the output
        do_reset();
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t3_active_out", out_v(), 8'h0C);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, ((i % 4) < 2) ? 3'b010 : 3'b011, 1'b0, 1'b0);
            tick();
            chk($sformatf("t3_toggle%0d_out", i), out_v(), 8'h0C);
        end
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        tick(); chk("t3_hold1_out", out_v(), 8'h0C);
        tick(); chk("t3_hold2_out", out_v(), 8'h0C);
        tick(); chk("t3_hold3_out", out_v(), 8'h0C);
        tick(); chk("t3_hold4_out", out_v(), 8'h08);
        chk("t3_hold4_pulse", 8'(pulse), 8'h01);
        chk("t3_err", 8'(err), 8'h00);

        // Illegal lifecycle regression MANUF -> UNPROV is sticky
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        tick(); chk("t4_err", 8'(err), 8'h01);
        chk("t4_out", out_v(), SAFE_V);
        chk("t4_pulse", 8'(pulse), 8'h01);
        chk("t4_cnt", cnt, 8'h03);
        drive(1'b0, 3'b011, 1'b0, 1'b0);
        tick(); tick();
        chk("t4_drop_err", 8'(err), 8'h01);
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        tick(); tick(); tick(); tick(); tick();
        chk("t4_sticky_err", 8'(err), 8'h01);
        chk("t4_sticky_out", out_v(), SAFE_V);
        do_reset();
        chk("t4_rst_err", 8'(err), 8'h00);

        // Reserved lifecycle while settling
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        tick(); chk("t5_rsvd_err", 8'(err), 8'h01);
        chk("t5_rsvd_out", out_v(), SAFE_V);
        chk("t5_rsvd_pulse", 8'(pulse), 8'h00);

        // Valid drop mid-settle, even alongside a reserved lifecycle, is not an error
        do_reset();
        drive(1'b1, 3'b000, 1'b1, 1'b0);
        tick(); tick();
        drive(1'b0, 3'b101, 1'b0, 1'b0);
        tick(); chk("t5_drop_err", 8'(err), 8'h00);
        chk("t5_drop_out", out_v(), SAFE_V);
        drive(1'b1, 3'b000, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("t5_restart_e3_out", out_v(), SAFE_V);
        tick(); chk("t5_restart_e4_out", out_v(), 8'h02);

        // Counter saturation over 300 output changes
        do_reset();
        drive(1'b1, 3'b111, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t6_start_cnt", cnt, 8'h00);
        for (int i = 0; i < 150; i++) begin
            drive(1'b1, 3'b111, 1'b1, 1'b0);
            tick(); tick(); tick(); tick();
            drive(1'b1, 3'b111, 1'b0, 1'b0);
            tick();
            if (i == 0)   chk("t6_cnt_after1", cnt, 8'h02);
            if (i == 126) chk("t6_cnt_after127", cnt, 8'hFE);
        end
        chk("t6_cnt_sat", cnt, 8'hFF);
        chk("t6_out", out_v(), SAFE_V);
        chk("t6_err", 8'(err), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
